// File: rtl/apb_rr_master_arbiter.sv
// APB master that shares one bus between two requesters with round-robin grant.
// Each command runs SETUP then ACCESS. A wait-state timeout can end ACCESS early. Completion is reported per requester.
module apb_rr_master_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  PSEL1,
  output logic                  PSEL2,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-2:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA1,
  input  logic [DATA_WIDTH-1:0] PRDATA2,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q;
  logic                  last_q, owner_q;
  logic [CW-1:0]         cnt_q;
  logic                  psel1_q, psel2_q, penable_q, pwrite_q;
  logic [ADDR_WIDTH-2:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  done0_q, done1_q, err0_q, err1_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic                  gnt0, gnt1;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  xfer_end, xfer_err;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == IDLE) begin
      gnt0 = req0_valid & (~req1_valid | last_q);
      gnt1 = req1_valid & (~req0_valid | ~last_q);
    end
  end

  assign cmd_addr = gnt1 ? req1_addr : req0_addr;
  assign rd_sel   = psel2_q ? PRDATA2 : PRDATA1;
  assign xfer_end = PREADY | (cnt_q == CW'(TIMEOUT - 1));
  assign xfer_err = ~PREADY | PSLVERR;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= '0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            owner_q  <= gnt1;
            last_q   <= gnt1;
            pwrite_q <= gnt1 ? req1_write : req0_write;
            pwdata_q <= gnt1 ? req1_wdata : req0_wdata;
            paddr_q  <= cmd_addr[ADDR_WIDTH-2:0];
            psel1_q  <= ~cmd_addr[ADDR_WIDTH-1];
            psel2_q  <= cmd_addr[ADDR_WIDTH-1];
            cnt_q    <= '0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (xfer_end) begin
            state_q   <= IDLE;
            psel1_q   <= 1'b0;
            psel2_q   <= 1'b0;
            penable_q <= 1'b0;
            cnt_q     <= '0;
            if (owner_q) begin
              done1_q <= 1'b1;
              err1_q  <= xfer_err;
              if (PREADY && !pwrite_q) rdata1_q <= rd_sel;
            end else begin
              done0_q <= 1'b1;
              err0_q  <= xfer_err;
              if (PREADY && !pwrite_q) rdata0_q <= rd_sel;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign req0_done  = done0_q;
  assign req1_done  = done1_q;
  assign req0_err   = err0_q;
  assign req1_err   = err1_q;
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign PSEL1      = psel1_q;
  assign PSEL2      = psel2_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;

endmodule

// File: doc/apb_rr_master_arbiter.md
Name: apb_rr_master_arbiter

Overview:
- Two-requester APB master controller that shares one APB bus between requester 0 and requester 1 using round-robin arbitration.
- Sequences each accepted command through the APB SETUP and ACCESS phases.
- Decodes address bit 8 to select slave 1 or slave 2, and returns read data, error and completion to the owning requester.
- Sits between on-chip command sources and the two APB slaves, replacing ad-hoc transfer/READ_WRITE driving.

Parameters:
- ADDR_WIDTH, 9, requester address width; the MSB selects the slave.
- DATA_WIDTH, 8, data width.
- TIMEOUT, 15, maximum consecutive ACCESS cycles with PREADY low before a forced error termination.

Ports:
- PCLK  in  1  clock, rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has a command.
- req0_write  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_WIDTH  command address.
- req0_wdata  in  DATA_WIDTH  write data.
- req0_ready  out  1  command accepted this cycle.
- req0_done  out  1  one-cycle completion pulse.
- req0_rdata  out  DATA_WIDTH  read result.
- req0_err  out  1  error flag, valid with done.
- req1_*  same set of ports as req0_*, for requester 1.
- PSEL1  out  1  slave 1 select.
- PSEL2  out  1  slave 2 select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH-1  slave-local address.
- PWDATA  out  DATA_WIDTH  write data.
- PRDATA1  in  DATA_WIDTH  slave 1 read data.
- PRDATA2  in  DATA_WIDTH  slave 2 read data.
- PREADY  in  1  slave ready; sampled for the selected slave.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async, PRESETn=0):
  - All outputs 0, FSM goes to IDLE, timeout counter cleared.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - Reset during SETUP or ACCESS: PSELx/PENABLE drop immediately, no done pulse, command discarded.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Grant is combinational. Only one valid: grant that requester. Both valid: grant the requester that is not last_grant.
  - reqN_ready=1 (combinational) for the granted requester only.
  - At the clock edge: latch write/addr/wdata, update last_grant, go to SETUP.
  - No valid: stay in IDLE, PSELx=PENABLE=0.
- SETUP (exactly 1 cycle):
  - PSEL1=~addr[8], PSEL2=addr[8], PENABLE=0.
  - PADDR=addr[ADDR_WIDTH-2:0], PWRITE and PWDATA taken from the latched command.
  - Next state: ACCESS.
- ACCESS:
  - PSELx held, PENABLE=1, timeout counter increments every cycle that PREADY=0.
  - PREADY=1: transfer ends. Capture PSLVERR into err. On a read, capture the PRDATA of the selected slave into reqN_rdata. Go to IDLE.
  - Counter reaches TIMEOUT with PREADY=0: forced termination with err=1, rdata unchanged, go to IDLE.
- Completion:
  - reqN_done is registered and pulses for 1 cycle in the IDLE cycle right after termination.
  - reqN_err is valid during the done pulse and holds until the next done for that requester.
  - reqN_rdata holds until the next read completion for that requester; writes do not modify it.
- Bus values: PADDR, PWRITE and PWDATA are stable from SETUP to the end of ACCESS and hold their last values in IDLE. PSEL1 and PSEL2 are never both 1.
- Latency: a zero-wait transfer takes 3 cycles (IDLE accept, SETUP, ACCESS), with done in the following cycle. Minimum back-to-back issue interval is 3 cycles.
- Simultaneous events: a new grant may occur in the same IDLE cycle in which the previous done pulse is asserted.
- Requester rule: a requester must hold valid and command fields stable until it sees ready.

Test Plan:
- Reset → after PRESETn rises: every output 0, IDLE. Assert PRESETn=0 during ACCESS of a pending write → PSEL1/PENABLE go low asynchronously, no req0_done.
- req0 write addr 0x003 data 0x06, PREADY=1:
  - T0: req0_ready=1.
  - T1: PSEL1=1, PADDR=0x03, PWDATA=0x06, PWRITE=1, PENABLE=0.
  - T2: PENABLE=1.
  - T3: req0_done=1, req0_err=0.
- req1 read addr 0x105, PREADY low for 2 ACCESS cycles, PRDATA2=0x05 → PSEL2=1, PADDR=0x05, ACCESS lasts 3 cycles, req1_rdata=0x05 with req1_done.
- Both requesters valid continuously → grant order 0,1,0,1,…; each ready pulse spaced ≥3 cycles; no starvation.
- Write addr 0x00E with PSLVERR=1 at PREADY → req0_err=1 with done, PSEL1 drops the next cycle.
- PREADY held 0 → after 15 ACCESS cycles the transfer aborts, err=1, rdata unchanged, FSM returns to IDLE.
